fifo_frame_reader: RTL and testbench
====================================

Name: fifo_frame_reader

Overview:
- Consumer at the read end of the demo FIFO.
- Issues single-cycle read strobes compatible with the FIFO's rising-edge-detected read input.
- Captures three consecutive words as one ALU frame: operand A, operand B, opcode.
- Presents the frame to the ALU with a valid/ready handshake; sits between the FIFO output and the ALU operand registers.

Parameters:
- DATA_WIDTH, 32, width of FIFO words and of op_a/op_b.
- OP_WIDTH, 4, opcode width; taken from the low bits of the third word.
- READ_LATENCY, 2, clock edges from a fifo_rd high cycle until fifo_dout holds the read word. Legal range 1..7.
- TIMEOUT_CYCLES, 1024, mid-frame empty-stall limit; used only with the optional feature.

Ports:
- clock, in, 1, system clock, rising edge.
- reset, in, 1, synchronous, active-high.
- fifo_empty, in, 1, FIFO empty flag.
- fifo_dout, in, DATA_WIDTH, FIFO read data.
- fifo_rd, out, 1, read strobe to the FIFO; high for exactly one cycle per word.
- op_a, out, DATA_WIDTH, frame word 0.
- op_b, out, DATA_WIDTH, frame word 1.
- opcode, out, OP_WIDTH, frame word 2, bits [OP_WIDTH-1:0].
- out_valid, out, 1, frame available.
- out_ready, in, 1, ALU accepts the frame.
- busy, out, 1, high in any state other than FETCH with word index 0.
- frame_cnt, out, 8, frames accepted; wraps 255 -> 0.
- timeout_err, out, 1, sticky stall error (see Optional Feature).

Behaviour:
- Reset is synchronous and active-high, on clock. All outputs go to 0. State = FETCH, word index = 0, wait counter = 0.
- All outputs are registered.
- FETCH: if fifo_empty = 0, go to PULSE; otherwise stay.
- PULSE: fifo_rd = 1 for this cycle only. Go to WAIT and load the wait counter with READ_LATENCY-1.
- WAIT: fifo_rd = 0. Decrement the counter. When it reaches 0, go to CAPTURE.
- CAPTURE: sample fifo_dout into the slot for the word index.
  - Index 0 -> op_a.
  - Index 1 -> op_b.
  - Index 2 -> opcode.
  - Index < 2: increment the index, go to FETCH.
  - Index 2: clear the index, go to PRESENT.
- fifo_rd therefore stays low for at least READ_LATENCY+1 cycles between pulses, which guarantees the FIFO's edge detector sees a distinct rising edge for every read.
- Per-word cost: at least READ_LATENCY+3 cycles (FETCH, PULSE, WAIT cycles, CAPTURE). Default: 5 cycles.
- out_valid rises on the edge after the third CAPTURE. Default: 15 cycles after the first FETCH that sees data.
- PRESENT:
  - out_valid = 1; op_a, op_b and opcode are held stable.
  - When out_valid && out_ready: out_valid falls on the next edge, frame_cnt increments, state returns to FETCH.
  - No new reads are issued while in PRESENT; this is the back-pressure mechanism.
- op_a, op_b and opcode change only in CAPTURE. Values from the previous frame persist until they are overwritten.
- fifo_empty is sampled only in FETCH. Going empty mid-frame makes the block wait in FETCH with the index preserved; it never reads from an empty FIFO.
- fifo_empty is ignored in PULSE, WAIT and CAPTURE.
- A reset in any state aborts the partial frame; captured words are discarded and all outputs are cleared.
- out_ready while not in PRESENT has no effect.
- frame_cnt wraps modulo 256.

Optional Feature:
- Macro: FIFO_FRAME_READER_TIMEOUT_EN.
- Defined:
  - A 16-bit stall counter counts cycles spent in FETCH with index != 0 and fifo_empty = 1.
  - The counter clears whenever fifo_empty = 0 or the index is 0.
  - When it reaches TIMEOUT_CYCLES: set timeout_err (sticky until reset), discard the partial frame (index -> 0), stay in FETCH.
  - op_a, op_b and opcode keep their last values.
- Not defined: no stall counter; timeout_err is tied to 0; a partial frame waits indefinitely.

Test Plan:
- Frame capture: push 0x5, 0x3, 0x2; out_ready = 1. Expect 3 fifo_rd pulses, each one cycle wide and 5 cycles apart; out_valid for one cycle with op_a = 5, op_b = 3, opcode = 2; frame_cnt = 1.
- Back-pressure: push 6 words with out_ready = 0. Expect out_valid held and op_a/op_b/opcode stable, with exactly 3 fifo_rd pulses. Raise out_ready: second frame delivered; frame_cnt = 2.
- Mid-frame stall: push 0xA, 0xB, wait 50 cycles, push 0x7. Expect no fifo_rd while fifo_empty = 1; frame delivered as op_a = 0xA, op_b = 0xB, opcode = 7.
- Reset mid-frame: push 0x1, 0x2; assert reset for 1 cycle after the second CAPTURE; then push 0x9, 0x8, 0x4. Expect all outputs 0 after reset and frame = 9, 8, 4.
- Timeout, macro defined, TIMEOUT_CYCLES = 16: push 1 word, then wait. Expect timeout_err = 1 after 16 empty cycles and busy = 0. Push 0x3, 0x4, 0x5: expect frame 3, 4, 5 delivered.
- Counter wrap: deliver 256 frames. Expect frame_cnt = 0 afterwards; fifo_rd pulse spacing never below READ_LATENCY+1 low cycles.

Source files
------------

// File: rtl/fifo_frame_reader.sv
// Read-side consumer of the demo FIFO: fetches three words per frame (op A, op B, opcode)
// and hands the frame to the ALU over valid/ready. Optional stall timeout: FIFO_FRAME_READER_TIMEOUT_EN.
module fifo_frame_reader #(
    parameter int DATA_WIDTH     = 32,
    parameter int OP_WIDTH       = 4,
    parameter int READ_LATENCY   = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd,
    output logic [DATA_WIDTH-1:0] op_a,
    output logic [DATA_WIDTH-1:0] op_b,
    output logic [OP_WIDTH-1:0]   opcode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic [7:0]            frame_cnt,
    output logic                  timeout_err
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_PULSE,
        S_WAIT,
        S_CAPTURE,
        S_PRESENT
    } state_e;

    localparam logic [2:0] WAIT_LOAD = 3'(READ_LATENCY - 1);

    if (READ_LATENCY < 1 || READ_LATENCY > 7 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("fifo_frame_reader: READ_LATENCY must be 1..7 and TIMEOUT_CYCLES 1..65535");
    end

    state_e                state_q;
    logic [1:0]            idx_q;
    logic [2:0]            wait_q;
    logic                  fifo_rd_q;
    logic [DATA_WIDTH-1:0] op_a_q;
    logic [DATA_WIDTH-1:0] op_b_q;
    logic [OP_WIDTH-1:0]   opcode_q;
    logic                  out_valid_q;
    logic                  busy_q;
    logic [7:0]            frame_cnt_q;

`ifdef FIFO_FRAME_READER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] stall_q;
    logic        timeout_err_q;
`endif

    // NOTE: non-blocking assignments only, so every branch below reads the pre-edge register values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_FETCH;
            idx_q       <= '0;
            wait_q      <= '0;
            fifo_rd_q   <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            opcode_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
`ifdef FIFO_FRAME_READER_TIMEOUT_EN
            stall_q       <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_FETCH: begin
`ifdef FIFO_FRAME_READER_TIMEOUT_EN
                    // A partial frame starved for too long is dropped; the captured words stay visible.
                    if (!fifo_empty || idx_q == 2'd0) begin
                        stall_q <= '0;
                    end else if (stall_q == TIMEOUT_LAST) begin
                        stall_q       <= '0;
                        timeout_err_q <= 1'b1;
                        idx_q         <= '0;
                        busy_q        <= 1'b0;
                    end else begin
                        stall_q <= stall_q + 16'd1;
                    end
`endif
                    if (!fifo_empty) begin
                        state_q   <= S_PULSE;
                        fifo_rd_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                S_PULSE: begin
                    fifo_rd_q <= 1'b0;
                    wait_q    <= WAIT_LOAD;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_q == 3'd0) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        wait_q <= wait_q - 3'd1;
                    end
                end
                S_CAPTURE: begin
                    case (idx_q)
                        2'd0:    op_a_q   <= fifo_dout;
                        2'd1:    op_b_q   <= fifo_dout;
                        default: opcode_q <= fifo_dout[OP_WIDTH-1:0];
                    endcase
                    if (idx_q == 2'd2) begin
                        idx_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_PRESENT;
                    end else begin
                        idx_q   <= idx_q + 2'd1;
                        busy_q  <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_PRESENT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                        busy_q      <= 1'b0;
                        state_q     <= S_FETCH;
                    end
                end
                default: begin
                    state_q     <= S_FETCH;
                    idx_q       <= '0;
                    fifo_rd_q   <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd   = fifo_rd_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign opcode    = opcode_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

`ifdef FIFO_FRAME_READER_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Directed bench for fifo_frame_reader with a small behavioural FIFO (2-edge read latency).
// Build with +define+FIFO_FRAME_READER_TIMEOUT_EN to include the stall-timeout scenario.
module tb_fifo_frame_reader;

    localparam int DW = 32;
    localparam int OW = 4;
    localparam int RL = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dout = '0;
    logic          out_ready = 1'b0;
    logic          fifo_rd;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [OW-1:0] opcode;
    logic          out_valid;
    logic          busy;
    logic [7:0]    frame_cnt;
    logic          timeout_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] stage = '0;
    int            pulse_times[$];
    int            last_pulse = -100;
    logic          rd_prev = 1'b0;

    fifo_frame_reader #(
        .DATA_WIDTH    (DW),
        .OP_WIDTH      (OW),
        .READ_LATENCY  (RL),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .op_a       (op_a),
        .op_b       (op_b),
        .opcode     (opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .frame_cnt  (frame_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // FIFO model: word popped on the edge closing the fifo_rd cycle, visible on dout one edge later.
    always @(posedge clock) begin
        if (fifo_rd) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL fifo_underflow: read strobe with %0d words stored at cycle %0d", q.size(), cyc);
            end else begin
                stage <= q.pop_front();
            end
        end
        fifo_dout  <= stage;
        fifo_empty <= (q.size() == 0);
    end

    // Strobe monitor: single-cycle width, minimum low gap, never while empty.
    always @(negedge clock) begin
        if (fifo_rd) begin
            checks++;
            if (rd_prev) begin
                errors++;
                $display("FAIL rd_width: fifo_rd high for 2+ cycles at cycle %0d, required 1", cyc);
            end
            if (!rd_prev) begin
                pulse_times.push_back(cyc);
                checks++;
                if (cyc - last_pulse - 1 < RL + 1) begin
                    errors++;
                    $display("FAIL rd_gap: low gap %0d cycles, required >= %0d", cyc - last_pulse - 1, RL + 1);
                end
                last_pulse = cyc;
                checks++;
                if (fifo_empty !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_when_empty: fifo_rd with fifo_empty=%b at cycle %0d", fifo_empty, cyc);
                end
            end
        end
        rd_prev = fifo_rd;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic push(input logic [DW-1:0] w);
        q.push_back(w);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset     = 1'b1;
        out_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        pulse_times.delete();
    endtask

    task automatic wait_valid(input string name, input int max_cyc);
        int n = 0;
        while (out_valid !== 1'b1 && n < max_cyc) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: out_valid=%b after %0d cycles, required 1", name, out_valid, max_cyc);
        end
    endtask

    task automatic check_frame(input string name, input logic [DW-1:0] a, input logic [DW-1:0] b,
                               input logic [OW-1:0] op);
        checks++;
        if (op_a !== a) begin errors++; $display("FAIL %s_op_a: got %h required %h", name, op_a, a); end
        checks++;
        if (op_b !== b) begin errors++; $display("FAIL %s_op_b: got %h required %h", name, op_b, b); end
        checks++;
        if (opcode !== op) begin errors++; $display("FAIL %s_opcode: got %h required %h", name, opcode, op); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({fifo_rd, out_valid, busy, timeout_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: rd/valid/busy/terr=%b required 0000", {fifo_rd, out_valid, busy, timeout_err});
        end
        checks++;
        if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d required 0", frame_cnt); end
        check_frame("reset", '0, '0, '0);
        reset = 1'b0;
    endtask

    task automatic test_frame_capture();
        do_reset();
        out_ready = 1'b1;
        push(32'h5); push(32'h3); push(32'h2);
        wait_valid("cap_valid", 100);
        check_frame("cap", 32'h5, 32'h3, 4'h2);
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL cap_valid_width: out_valid=%b required 0", out_valid); end
        checks++;
        if (frame_cnt !== 8'd1) begin errors++; $display("FAIL cap_frame_cnt: got %0d required 1", frame_cnt); end
        checks++;
        if (pulse_times.size() != 3) begin
            errors++; $display("FAIL cap_pulses: got %0d required 3", pulse_times.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (pulse_times[i+1] - pulse_times[i] != 5) begin
                    errors++;
                    $display("FAIL cap_spacing: got %0d cycles required 5", pulse_times[i+1] - pulse_times[i]);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        push(32'h11); push(32'h22); push(32'hABC3);
        push(32'h44); push(32'h55); push(32'h1236);
        wait_valid("bp_valid", 100);
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b1 || op_a !== 32'h11) begin
                errors++;
                $display("FAIL bp_hold: valid=%b op_a=%h required 1/00000011", out_valid, op_a);
            end
        end
        check_frame("bp_first", 32'h11, 32'h22, 4'h3);
        checks++;
        if (pulse_times.size() != 3) begin errors++; $display("FAIL bp_pulses: got %0d required 3", pulse_times.size()); end
        checks++;
        if (frame_cnt !== 8'd0) begin errors++; $display("FAIL bp_cnt_held: got %0d required 0", frame_cnt); end
        out_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || frame_cnt !== 8'd1) begin
            errors++;
            $display("FAIL bp_accept: valid=%b frame_cnt=%0d required 0/1", out_valid, frame_cnt);
        end
        wait_valid("bp_valid2", 100);
        check_frame("bp_second", 32'h44, 32'h55, 4'h6);
        @(negedge clock);
        checks++;
        if (frame_cnt !== 8'd2) begin errors++; $display("FAIL bp_frame_cnt: got %0d required 2", frame_cnt); end
    endtask

    task automatic test_mid_frame_stall();
        do_reset();
        out_ready = 1'b1;
        push(32'hA); push(32'hB);
        repeat (50) @(negedge clock);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL stall_state: busy=%b valid=%b required 1/0", busy, out_valid);
        end
        checks++;
        if (pulse_times.size() != 2) begin errors++; $display("FAIL stall_pulses: got %0d required 2", pulse_times.size()); end
        push(32'h7);
        wait_valid("stall_valid", 100);
        check_frame("stall", 32'hA, 32'hB, 4'h7);
        @(negedge clock);
    endtask

    task automatic test_reset_mid_frame();
        int n = 0;
        do_reset();
        out_ready = 1'b1;
        push(32'h1); push(32'h2);
        while (op_b !== 32'h2 && n < 100) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (op_b !== 32'h2) begin errors++; $display("FAIL rmf_second_capture: op_b=%h required 00000002", op_b); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({fifo_rd, out_valid, busy, timeout_err} !== 4'b0000 || frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rmf_clear: rd/valid/busy/terr=%b cnt=%0d required 0000/0",
                     {fifo_rd, out_valid, busy, timeout_err}, frame_cnt);
        end
        check_frame("rmf_clear", '0, '0, '0);
        push(32'h9); push(32'h8); push(32'h4);
        wait_valid("rmf_valid", 100);
        check_frame("rmf", 32'h9, 32'h8, 4'h4);
        @(negedge clock);
        checks++;
        if (frame_cnt !== 8'd1) begin errors++; $display("FAIL rmf_frame_cnt: got %0d required 1", frame_cnt); end
    endtask

`ifdef FIFO_FRAME_READER_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        do_reset();
        out_ready = 1'b1;
        push(32'h1);
        while (op_a !== 32'h1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        repeat (8) @(negedge clock);
        checks++;
        if (timeout_err !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL to_early: terr=%b busy=%b required 0/1", timeout_err, busy);
        end
        n = 0;
        while (timeout_err !== 1'b1 && n < 30) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL to_fire: terr=%b busy=%b required 1/0", timeout_err, busy);
        end
        checks++;
        if (op_a !== 32'h1) begin errors++; $display("FAIL to_keep_op_a: got %h required 00000001", op_a); end
        push(32'h3); push(32'h4); push(32'h5);
        wait_valid("to_valid", 100);
        check_frame("to", 32'h3, 32'h4, 4'h5);
        checks++;
        if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b required 1", timeout_err); end
        @(negedge clock);
    endtask
`endif

    task automatic test_counter_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 256; k++) begin
            push(32'h1000 + k); push(32'h2000 + k); push(32'(k));
        end
        for (int k = 0; k < 256; k++) begin
            wait_valid("wrap_valid", 40);
            checks++;
            if (op_a !== 32'h1000 + k || op_b !== 32'h2000 + k || opcode !== 4'(k)) begin
                errors++;
                $display("FAIL wrap_frame%0d: got %h/%h/%h", k, op_a, op_b, opcode);
            end
            checks++;
            if (frame_cnt !== 8'(k)) begin errors++; $display("FAIL wrap_cnt%0d: got %0d required %0d", k, frame_cnt, k); end
            @(negedge clock);
        end
        checks++;
        if (frame_cnt !== 8'd0) begin errors++; $display("FAIL wrap_final: frame_cnt=%0d required 0", frame_cnt); end
        checks++;
        if (pulse_times.size() != 768) begin errors++; $display("FAIL wrap_pulses: got %0d required 768", pulse_times.size()); end
    endtask

    initial begin
        test_reset();
        test_frame_capture();
        test_back_pressure();
        test_mid_frame_stall();
        test_reset_mid_frame();
`ifdef FIFO_FRAME_READER_TIMEOUT_EN
        test_timeout();
`endif
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
